mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Parametrised elastic MEM->WB pipeline stage for the scalar+SIMD (AES) core.
//  Registers the scalar load data, the LANES-wide vector ALU and S-box results,
//  and the writeback controls, with valid/ready flow control, flush and stall.
//  Sits between the memory stage and the scalar/vector register-file writeback mux.
// PARAMETERS
//  XLEN     32  scalar datapath width (mem_data)
//  ELEM_W   32  width of one SIMD lane
//  LANES    4   SIMD lane count; VLEN = LANES*ELEM_W
//  RADDR_W  5   register index width
// PORTS
//  clk            in   1        stage clock, all flops on posedge
//  rst_n          in   1        asynchronous active-low reset
//  flush          in   1        synchronous kill of all held and incoming entries
//  in_valid       in   1        MEM side presents an entry
//  in_ready       out  1        stage can accept this cycle
//  in_mem_data    in   XLEN     load data
//  in_alu_result  in   VLEN     scalar result in lane 0, vector result in all lanes
//  in_sbox        in   VLEN     S-box lookup result per lane
//  in_rd          in   RADDR_W  destination register
//  in_mem_to_reg  in   2        wb_sel_e: 0=ALU 1=MEM 2=SBOX 3=reserved
//  in_reg_write   in   1        scalar RF write request
//  in_vreg_write  in   1        vector RF write request
//  in_lane_mask   in   LANES    per-lane vector write enables
//  out_valid      out  1        WB entry valid
//  out_ready      in   1        WB consumes entry (tie 1 when WB never stalls)
//  out_*          out  (as in_*) registered payload, same names/widths as in_*
//  stall_cnt      out  32       saturating count of cycles out_valid&&!out_ready
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* payload=0, stall_cnt=0, in_ready=1, skid empty.
//  - Accept when in_valid&&in_ready; data visible on out_* next cycle (latency 1).
//  - Consume when out_valid&&out_ready. Entries leave in acceptance order.
//  - Base (1 entry): in_ready = !out_valid || out_ready (combinational pass-through).
//  - Accept+consume same cycle: new entry replaces old, out_valid stays 1.
//  - Held entry stable: out_* must not change while out_valid&&!out_ready.
//  - out_reg_write = out_valid & held reg_write & (held rd != 0); x0 never written.
//  - out_vreg_write = out_valid & held vreg_write; out_lane_mask = 0 when !out_valid.
//  - in_mem_to_reg==3 is captured but forces out_reg_write=out_vreg_write=0.
//  - flush: next cycle out_valid=0 and skid empty; same-cycle incoming entry is
//    dropped; payload flops keep old values (don't-care), write enables gated to 0.
//    flush has priority over accept and consume; stall_cnt unaffected.
//  - stall_cnt increments by 1 when out_valid&&!out_ready&&!flush; holds at 2^32-1.
//  - rst_n low mid-transfer: entry discarded, outputs to reset values immediately.
// CONFIGURATION
//  SKID_BUFFER_EN defined: 2-entry stage (main + skid slot); in_ready is a flop
//   = !skid_valid, no combinational path out_ready->in_ready. Entry accepted while
//   main is held and !out_ready goes to skid; on consume, skid moves to main the
//   same cycle. Full throughput with out_ready=1; latency still 1 cycle.
//  Not defined: single entry, in_ready as in Base above, skid logic absent.
// STRUCTURE
//  Package mem_wb_pkg: wb_sel_e enum (WB_ALU, WB_MEM, WB_SBOX, WB_RSV);
//   mem_wb_payload_t packed struct parametrised via localparams XLEN/VLEN/RADDR_W/LANES
//   defaults; STALL_CNT_W=32.
//  Sub-module pipe_slot: one payload+valid register with load/clear enables;
//   instantiated once for main, once more for skid under SKID_BUFFER_EN.
//  Top: handshake/flush control, write-enable gating, stall counter.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, all out_*=0, stall_cnt=0.
//  2 Streaming: 8 entries rd=1..8, out_ready=1 -> out_rd 1..8 on consecutive cycles,
//    each 1 cycle after accept, no bubbles (both configs).
//  3 Backpressure: out_ready=0 for 5 cycles holding rd=3 -> out_* constant,
//    stall_cnt=5; base in_ready=0; SKID: one more entry (rd=4) accepted then
//    in_ready=0; release -> rd=3 then rd=4, none lost or duplicated.
//  4 Flush: flush with held entry and in_valid=1 (rd=9) -> next cycle out_valid=0,
//    rd=9 never appears, out_reg_write=out_vreg_write=0.
//  5 Gating: rd=0 reg_write=1 -> out_reg_write=0; mem_to_reg=3 -> both writes 0;
//    lane_mask=4'b0101, vreg_write=1 -> out_lane_mask=4'b0101.
//  6 Async reset mid-stall: rst_n low while held -> out_valid drops without clk edge.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// ----------------------------------------------------------------------------
// mem_wb_pkg
// Shared types and constants for the MEM->WB pipeline stage.
//   wb_sel_e         : writeback source select (ALU / MEM / SBOX / reserved)
//   mem_wb_payload_t : payload layout at the default widths, field order
//                      matches the flat packing used inside mem_wb_stage
//   wb_sel_writes    : true when a select value is allowed to write a RF
// ----------------------------------------------------------------------------
package mem_wb_pkg;

   localparam int XLEN        = 32;
   localparam int ELEM_W      = 32;
   localparam int LANES       = 4;
   localparam int VLEN        = LANES * ELEM_W;
   localparam int RADDR_W     = 5;
   localparam int STALL_CNT_W = 32;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_SBOX = 2'd2,
      WB_RSV  = 2'd3
   } wb_sel_e;

   typedef struct packed {
      logic [XLEN-1:0]    mem_data;
      logic [VLEN-1:0]    alu_result;
      logic [VLEN-1:0]    sbox;
      logic [RADDR_W-1:0] rd;
      wb_sel_e            mem_to_reg;
      logic               reg_write;
      logic               vreg_write;
      logic [LANES-1:0]   lane_mask;
   } mem_wb_payload_t;

   // The reserved select is carried through the stage but never writes.
   function automatic logic wb_sel_writes(input logic [1:0] sel);
      return sel != WB_RSV;
   endfunction

endpackage

// File: rtl/mem_wb_stage_pipe_slot.sv
// ----------------------------------------------------------------------------
// pipe_slot
// One pipeline entry: a payload register plus its valid flag.
//   clk     : stage clock
//   rst_n   : asynchronous active-low reset (payload and valid to 0)
//   load_i  : capture data_i and mark the slot valid
//   clear_i : mark the slot empty; wins over load_i, payload is left as is
//   data_i  : incoming payload
//   data_o  : held payload
//   valid_o : slot holds an entry
// ----------------------------------------------------------------------------
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         valid_o
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
// Elastic MEM->WB stage: registers scalar load data, the vector ALU and S-box
// results and the writeback controls, with valid/ready flow control, flush
// and a saturating stall counter.
//
// Optional feature macro: SKID_BUFFER_EN
//   defined   : two entries (main + skid); in_ready comes straight from the
//               skid valid flop, so there is no out_ready->in_ready path.
//   undefined : single entry; in_ready = !out_valid || out_ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      drop held and same-cycle incoming entries
//   in_valid / in_ready        MEM side handshake
//   in_mem_data .. in_lane_mask  incoming payload
//   out_valid / out_ready      WB side handshake
//   out_mem_data .. out_lane_mask  registered payload; write enables gated
//   stall_cnt                  saturating count of out_valid && !out_ready
// ----------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int XLEN    = 32,
   parameter int ELEM_W  = 32,
   parameter int LANES   = 4,
   parameter int RADDR_W = 5,
   parameter int VLEN    = LANES * ELEM_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_mem_data,
   input  logic [VLEN-1:0]    in_alu_result,
   input  logic [VLEN-1:0]    in_sbox,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic [1:0]         in_mem_to_reg,
   input  logic               in_reg_write,
   input  logic               in_vreg_write,
   input  logic [LANES-1:0]   in_lane_mask,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_mem_data,
   output logic [VLEN-1:0]    out_alu_result,
   output logic [VLEN-1:0]    out_sbox,
   output logic [RADDR_W-1:0] out_rd,
   output logic [1:0]         out_mem_to_reg,
   output logic               out_reg_write,
   output logic               out_vreg_write,
   output logic [LANES-1:0]   out_lane_mask,
   output logic [31:0]        stall_cnt
);

   import mem_wb_pkg::*;

   localparam int PW = XLEN + 2 * VLEN + RADDR_W + 2 + 1 + 1 + LANES;

   logic [PW-1:0] in_pl;
   logic [PW-1:0] main_d_pl, main_q_pl;
   logic          main_valid;
   logic          main_load, main_clear;
   logic          accept, consume;

   logic          held_reg_write, held_vreg_write;
   logic [LANES-1:0] held_lane_mask;

   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   assign in_pl = {in_mem_data, in_alu_result, in_sbox, in_rd,
                   in_mem_to_reg, in_reg_write, in_vreg_write, in_lane_mask};

   // flush masks the incoming entry so it can never be captured
   assign accept  = in_valid && in_ready && !flush;
   assign consume = main_valid && out_ready;

`ifdef SKID_BUFFER_EN
   logic [PW-1:0] skid_q_pl;
   logic          skid_valid;
   logic          skid_load, skid_clear, skid_move;

   // skid_valid is a flop output, so in_ready is registered
   assign in_ready = !skid_valid;

   // When the main entry leaves, a waiting skid entry takes its place.
   assign skid_move  = consume && skid_valid;
   // Incoming entry parks in the skid only when main is occupied and stays.
   assign skid_load  = accept && main_valid && !consume;
   assign skid_clear = flush || skid_move;

   assign main_load  = skid_move || (accept && (!main_valid || consume));
   assign main_clear = flush || (consume && !main_load);
   assign main_d_pl  = skid_move ? skid_q_pl : in_pl;

   pipe_slot #(.W(PW)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (in_pl),
      .data_o  (skid_q_pl),
      .valid_o (skid_valid)
   );
`else
   assign in_ready   = !main_valid || out_ready;
   assign main_load  = accept;
   assign main_clear = flush || (consume && !accept);
   assign main_d_pl  = in_pl;
`endif

   pipe_slot #(.W(PW)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (main_load),
      .clear_i (main_clear),
      .data_i  (main_d_pl),
      .data_o  (main_q_pl),
      .valid_o (main_valid)
   );

   assign {out_mem_data, out_alu_result, out_sbox, out_rd, out_mem_to_reg,
           held_reg_write, held_vreg_write, held_lane_mask} = main_q_pl;

   assign out_valid = main_valid;

   // After a flush the payload flops keep stale values; the enables below
   // are what guarantee nothing stale reaches a register file.
   assign out_reg_write  = main_valid && held_reg_write && (out_rd != '0)
                           && wb_sel_writes(out_mem_to_reg);
   assign out_vreg_write = main_valid && held_vreg_write
                           && wb_sel_writes(out_mem_to_reg);
   assign out_lane_mask  = main_valid ? held_lane_mask : '0;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid && !out_ready && !flush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule
